// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction FIFO and issue sequencer for the bit-serial core
// Buffers instruction words and issues them one at a time, waiting for core completion.
module instr_sequencer #(
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 32,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [15:0]                wr_data,
  input  logic                       run_mode,
  input  logic                       step_req,
  input  logic                       clr,
  input  logic                       core_done,
  output logic [3:0]                 opcode,
  output logic [11:0]                instr,
  output logic                       core_start,
  output logic                       busy,
  output logic                       halted,
  output logic                       error,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 retired
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [11:0]     instr_q, instr_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [7:0]      retired_q, retired_d;
  logic            overflow_q, overflow_d;

  logic            full;
  logic            go;
  logic            push;
  logic            pop;
  logic [15:0]     head;

  // Full/empty come from registered occupancy, so a pop never frees room for a same-cycle push.
  assign full = (count_q == CW'(DEPTH));
  assign head = mem_q[rd_ptr_q];
  assign go   = (state_q == S_IDLE) && (count_q != '0) && (run_mode || step_req);
  assign pop  = go && !clr;
  assign push = wr_en && !clr && !full;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    instr_d   = instr_q;
    wd_d      = wd_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (head[15:12] == HALT_OP) begin
            state_d = S_HALTED;
          end else begin
            opcode_d = head[15:12];
            instr_d  = head[11:0];
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion in the last watchdog cycle still counts as a normal retire.
        if (core_done) begin
          state_d   = S_IDLE;
          retired_d = retired_q + 8'd1;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d   = S_IDLE;
      opcode_d  = opcode_q;
      instr_d   = instr_q;
      wd_d      = '0;
      retired_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en && !clr && full);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      opcode_q   <= '0;
      instr_q    <= '0;
      wd_q       <= '0;
      retired_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      opcode_q   <= opcode_d;
      instr_q    <= instr_d;
      wd_q       <= wd_d;
      retired_q  <= retired_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign opcode     = opcode_q;
  assign instr      = instr_q;
  assign core_start = (state_q == S_ISSUE);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted     = (state_q == S_HALTED);
  assign error      = (state_q == S_ERR);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign retired    = retired_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Upstream instruction sequencer for the bit-serial CPU core. It buffers loaded instruction words in a small FIFO and issues them one at a time to the core. Each instruction's opcode and operand fields are held stable while it executes. The block then waits for the core's completion pulse before issuing the next instruction, in either free-run or single-step mode. It also handles a local HALT opcode, detects stuck execution with a watchdog, and counts retired instructions.

Parameters:
DEPTH, 4, FIFO depth in 16-bit instruction words; power of 2, minimum 2
TIMEOUT, 32, maximum cycles in WAIT without core_done before error; minimum 2
HALT_OP, 4'hF, opcode consumed locally as halt; never issued to the core

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
wr_en  input  1  push wr_data into the FIFO
wr_data  input  16  instruction word: [15:12] opcode, [11:0] instr fields
run_mode  input  1  1 = free-run, 0 = single-step
step_req  input  1  one-cycle step pulse (debounced button edge)
clr  input  1  synchronous clear: flush FIFO, leave HALTED/ERR, zero retired and sticky flags
core_done  input  1  one-cycle pulse from core: current instruction finished
opcode  output  4  opcode to core, held from ISSUE until the next issue
instr  output  12  operand fields to core, held likewise
core_start  output  1  one-cycle start pulse to core
busy  output  1  high in ISSUE or WAIT
halted  output  1  high in HALTED
error  output  1  high in ERR
overflow  output  1  sticky: a write was dropped because the FIFO was full
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy
retired  output  8  count of instructions completed by core_done; wraps 255->0

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; FIFO empty; opcode=0, instr=0, core_start=0, busy=0, halted=0, error=0, overflow=0, fifo_count=0, retired=0. Reset mid-execution abandons the instruction; no core_start follows.
- Precedence: rstn, then clr, then normal operation. In clr cycles, wr_en is ignored.
- FIFO push:
  - wr_en with fifo_count<DEPTH pushes at that edge.
  - wr_en when full drops the word and sets overflow, even if a pop occurs in the same cycle.
  - Pushes are accepted in every state.
- FIFO pop: occurs only on an IDLE decision. Full/empty are judged from registered occupancy. A word pushed into an empty FIFO is poppable no earlier than the following cycle. A simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HALTED, ERR.
- IDLE:
  - Go condition: fifo_count>0 and (run_mode=1 or step_req=1).
  - On go, pop the head word.
  - If the head opcode is HALT_OP, go to HALTED; opcode/instr are unchanged.
  - Otherwise, register opcode/instr from the word and go to ISSUE.
  - Without go, stay in IDLE.
- ISSUE: core_start=1 for exactly this one cycle. Clear the watchdog. Go to WAIT.
- WAIT:
  - core_done=1 -> IDLE, retired+1.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without core_done, go to ERR.
  - If core_done arrives in that same final cycle, completion wins.
- HALTED / ERR: hold state; outputs are held. The FIFO keeps accepting writes. Only clr (or reset) returns to IDLE; clr also empties the FIFO.
- Ignored inputs:
  - step_req outside IDLE is ignored and not queued.
  - core_done outside WAIT is ignored.
  - run_mode is sampled only at IDLE decisions.
- Latency:
  - Go in cycle N -> core_start in N+1.
  - core_done in cycle M -> earliest next core_start in M+2 (IDLE in M+1, ISSUE in M+2).
- Core connections: core_start drives the core's start/btn_edge input; the core's completion drives core_done. opcode/instr never change while busy=1.

Test Plan:
- Reset, push 0x8123 and 0x2045, run_mode=1, core_done 9 cycles after each core_start -> two core_start pulses; opcode/instr=8/0x123 then 2/0x045; retired=2; fifo_count=0; ends in IDLE.
- run_mode=0, push 3 words, single step_req -> exactly one core_start one cycle later; fifo_count 3->2. step_req pulses during WAIT have no effect. The next step_req after core_done issues word 2.
- Push 0x1001, 0xF000, 0x1002 in run mode -> one issue, then halted=1 with fifo_count=1 and no further core_start. clr -> IDLE, fifo_count=0, retired=0.
- With DEPTH=4, push 5 words while in HALTED -> fifo_count=4, overflow=1. A push together with an IDLE pop when full is still dropped.
- Issue an instruction and never assert core_done -> error=1 exactly TIMEOUT cycles after entering WAIT; busy=0. core_done on cycle TIMEOUT-1 instead -> retired+1, no error.
- Assert rstn=0 during WAIT -> all outputs at reset values the next cycle; no core_start follows; the FIFO is empty.
